// File: rtl/seq_mult_16_pkg.sv
// Shared constants, FSM encoding and carry-lookahead helpers for the
// sequential 16x16 multiplier.
package seq_mult_16_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned ITER  = 16;
    localparam int unsigned CNT_W = 4;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Carry into each of four bit positions, fully expanded from cin.
    function automatic logic [3:0] cla_cin(input logic [2:0] p, input logic [2:0] g,
                                           input logic cin);
        logic [3:0] c;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        return c;
    endfunction

    function automatic logic cla_gen(input logic [3:0] p, input logic [3:0] g);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

endpackage

// File: rtl/seq_mult_16_if.sv
// Handshake and operand/result bundle between a controller and seq_mult_16.
interface seq_mult_16_if;
    import seq_mult_16_pkg::*;

    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );

endinterface

// File: rtl/seq_mult_16_lookahead.sv
// 16-bit two-level carry-lookahead adder (four 4-bit groups plus a group
// lookahead stage), used as the multiplier's per-iteration adder.
module bit_16_lookahead
    import seq_mult_16_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout,
    output logic        p,
    output logic        g
);

    logic [15:0] bit_p;
    logic [15:0] bit_g;
    logic [3:0]  grp_p;
    logic [3:0]  grp_g;
    logic [3:0]  grp_cin;

    assign bit_p = a ^ b;
    assign bit_g = a & b;

    for (genvar n = 0; n < 4; n++) begin : g_nib
        logic [3:0] nib_c;

        assign grp_p[n] = &bit_p[4*n +: 4];
        assign grp_g[n] = cla_gen(bit_p[4*n +: 4], bit_g[4*n +: 4]);
        assign nib_c    = cla_cin(bit_p[4*n +: 3], bit_g[4*n +: 3], grp_cin[n]);
        assign sum[4*n +: 4] = bit_p[4*n +: 4] ^ nib_c;
    end

    assign grp_cin = cla_cin(grp_p[2:0], grp_g[2:0], cin);
    assign p       = &grp_p;
    assign g       = cla_gen(grp_p, grp_g);
    assign cout    = g | (p & cin);

endmodule

// File: rtl/seq_mult_16.sv
// Sequential 16x16 unsigned shift-and-add multiplier: one add/shift per clock,
// 16 iterations per product, start/busy/done handshake.
module seq_mult_16
    import seq_mult_16_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    seq_mult_16_if.slave  bus
);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     mq_q, mq_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     add_b;
    logic [WIDTH-1:0]     add_sum;
    logic                 add_cout;
    logic                 add_p;
    logic                 add_g;
    logic                 unused_pg;
    logic [2*WIDTH-1:0]   shifted;

    assign add_b = mq_q[0] ? mcand_q : '0;

    bit_16_lookahead u_adder (
        .a    (acc_q),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout),
        .p    (add_p),
        .g    (add_g)
    );

    // Group propagate/generate are not needed by the multiplier.
    assign unused_pg = add_p ^ add_g;

    // Low bit of mq is consumed; the adder carry lands in acc[15].
    assign shifted = {add_cout, add_sum, mq_q[WIDTH-1:1]};

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        count_d   = count_q;
        product_d = product_q;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    mcand_d = bus.a;
                    mq_d    = bus.b;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                {acc_d, mq_d} = shifted;
                count_d       = count_q + 1'b1;
                if (count_q == LAST_ITER) begin
                    product_d = shifted;
                    state_d   = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            mcand_q   <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    assign bus.busy    = (state_q == StRun) || (state_q == StDone);
    assign bus.done    = (state_q == StDone);
    assign bus.product = product_q;

endmodule

// File: doc/seq_mult_16.md
Name: seq_mult_16

Overview:
- Sequential 16x16 unsigned shift-and-add multiplier producing a 32-bit product.
- Sits directly downstream of the team's 16-bit carry-lookahead adder (bit_16_lookahead) and consumes its sum and carry-out once per cycle.
- One add/shift iteration per clock, 16 iterations per product.
- start/busy/done handshake for a controlling datapath or testbench.

Parameters:
- WIDTH, 16, operand width; only 16 supported because the adder is fixed at 16 bits.
- ITER, 16, number of add/shift iterations; must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  16  multiplicand; captured on accepted start
- b  input  16  multiplier; captured on accepted start
- busy  output  1  high in RUN and DONE; low in IDLE
- done  output  1  one-cycle pulse; product valid
- product  output  32  result register; held until next completion or reset

Behaviour:
- Reset (rst=1 at rising edge): state=IDLE, busy=0, done=0, product=0, count=0, acc=0, mq=0, mcand=0.
- Reset has priority over every other event, including mid-RUN. An aborted operation produces no done and leaves product=0.
- Internal registers:
  - mcand[15:0]: multiplicand.
  - acc[15:0]: upper partial product.
  - mq[15:0]: multiplier, low product bits shift in here.
  - count[3:0]: iteration counter.
- Adder hookup: A=acc, B=(mq[0] ? mcand : 16'h0), cin=0. sum and cout are used; p and g are left unconnected.
- IDLE:
  - start=1 at an edge → mcand=a, mq=b, acc=0, count=0, state=RUN.
  - start=0 → remain in IDLE.
- RUN, each edge:
  - {acc, mq} ← {cout, sum, mq[15:1]}, i.e. a 33-bit right shift of {cout,sum,mq}.
  - count ← count+1.
  - On the edge where count==15: also product ← {cout, sum, mq[15:1]}, state=DONE.
  - start is ignored throughout RUN.
- DONE:
  - done=1 for exactly this one cycle.
  - Next edge → IDLE, regardless of start. start asserted in DONE is not accepted.
- Latency: start accepted at edge k → done high during the cycle following edge k+16 → IDLE after edge k+17.
- Minimum issue interval is 18 cycles; back-to-back start held high is accepted on the first IDLE edge.
- product changes only on the final RUN edge; it is stable while busy=0 and during DONE.
- Width rules:
  - The carry out of the 16-bit add is never lost; it becomes acc[15] after the shift.
  - The maximum result 0xFFFF*0xFFFF = 0xFFFE0001 fits in 32 bits.
  - count wraps from 15 to 0 only on the transition to DONE.
- Operands a/b may change freely after the accept edge without affecting the result.
- busy and done are registered (decoded from the state register only), with no combinational path from start.

Decomposition:
- Shared package/header:
  - WIDTH=16, ITER=16.
  - State encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE on the next edge.
- One sub-module: bit_16_lookahead, instantiated once as the iteration adder.
- FSM, counter and shift register live in seq_mult_16 itself.

Test Plan:
- Reset, then a=0x0003, b=0x0005, start pulse at edge k → done=1 exactly in the cycle after edge k+16, product=0x0000000F, busy falls after edge k+17.
- a=0xFFFF, b=0xFFFF → product=0xFFFE0001 (exercises adder cout every iteration); a=0x8000, b=0x0002 → 0x00010000.
- a=0x0000, b=0x1234 and a=0x1234, b=0x0000 → product=0x00000000, same 17-cycle latency; done still pulses once.
- Start a=0x00FF, b=0x0101, then pulse start with a=0x0002, b=0x0002 at RUN iteration 5 and again in DONE → both ignored, product=0x0000FFFF, single done pulse.
- Start a=0x1234, b=0x5678, assert rst at RUN iteration 8 → next cycle busy=0, done=0, product=0, and no done ever appears. A following start with a=0x0007, b=0x0009 → product=0x0000003F.
- Hold start=1 continuously with a=0x0010, b=0x0010 → products of 0x00000100 on every 18-cycle period, done pulses spaced exactly 18 cycles apart.
